// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU opcodes, register-address width and
// the EX/MEM payload carried through the stage's skid buffer.
package mips_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    localparam logic [3:0] ALU_AND  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_ADD  = 4'd3;
    localparam logic [3:0] ALU_SUB  = 4'd4;
    localparam logic [3:0] ALU_EQ   = 4'd5;
    localparam logic [3:0] ALU_MULT = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;

    typedef struct packed {
        logic [XLEN-1:0]    result;
        logic [XLEN-1:0]    store_data;
        logic [RADDR_W-1:0] dest;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
    } ex_mem_payload_t;

    localparam int PAYLOAD_W = $bits(ex_mem_payload_t);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } ex_state_t;

    // Only signed ADD/SUB can raise an overflow trap; MULT and logic ops never do.
    function automatic logic is_trapping_op(input logic [3:0] op);
        logic r;
        case (op)
            ALU_ADD, ALU_SUB: r = 1'b1;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The caller qualifies in_valid with
// its own registered ready, so a push never arrives while the skid entry is full.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         skid_full_nxt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_r;
    logic         skid_valid_r;
    logic [W-1:0] main_data_r;
    logic [W-1:0] skid_data_r;

    logic         main_valid_s;
    logic         skid_valid_s;
    logic [W-1:0] main_data_s;
    logic [W-1:0] skid_data_s;
    logic         drain_s;

    // Next-entry selection: the skid entry refills main before any new input.
    always_comb begin
        main_valid_s = main_valid_r;
        skid_valid_s = skid_valid_r;
        main_data_s  = main_data_r;
        skid_data_s  = skid_data_r;
        drain_s      = main_valid_r & out_ready;
        if (flush) begin
            main_valid_s = 1'b0;
            skid_valid_s = 1'b0;
        end else if (!main_valid_r || drain_s) begin
            if (skid_valid_r) begin
                main_valid_s = 1'b1;
                main_data_s  = skid_data_r;
                skid_valid_s = 1'b0;
            end else if (in_valid) begin
                main_valid_s = 1'b1;
                main_data_s  = in_data;
            end else begin
                main_valid_s = 1'b0;
            end
        end else begin
            if (in_valid) begin
                skid_valid_s = 1'b1;
                skid_data_s  = in_data;
            end else begin
                skid_valid_s = skid_valid_r;
            end
        end
    end

    // Entry storage; data is cleared on reset so the outputs start at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            main_data_r  <= '0;
            skid_data_r  <= '0;
        end else begin
            main_valid_r <= main_valid_s;
            skid_valid_r <= skid_valid_s;
            main_data_r  <= main_data_s;
            skid_data_r  <= skid_data_s;
        end
    end

    assign skid_full_nxt = skid_valid_s;
    assign out_valid     = main_valid_r;
    assign out_data      = main_data_r;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: registers ALU results behind a skid buffer, resolves
// branches and raises precise overflow traps. Optional bypass: EX_MEM_FWD_EN.
module ex_mem_stage #(
    parameter int SIZE    = mips_pkg::XLEN,
    parameter int RADDR_W = mips_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_op,
    input  logic [SIZE-1:0]    alu_out,
    input  logic               alu_zero,
    input  logic               alu_ovf,
    input  logic               trap_en,
    input  logic [SIZE-1:0]    store_data,
    input  logic [RADDR_W-1:0] dest_reg,
    input  logic               reg_write,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               branch,
    input  logic               flush,
    input  logic               exc_ack,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SIZE-1:0]    m_result,
    output logic [SIZE-1:0]    m_store_data,
    output logic [RADDR_W-1:0] m_dest,
    output logic               m_reg_write,
    output logic               m_mem_read,
    output logic               m_mem_write,
    output logic               branch_taken,
    output logic               exc_ovf
`ifdef EX_MEM_FWD_EN
    ,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_reg,
    output logic [SIZE-1:0]    fwd_data
`endif
);

    import mips_pkg::*;

    ex_state_t       state_r;
    ex_state_t       state_s;
    logic            in_ready_r;
    logic            exc_ovf_r;
    logic            branch_taken_r;
    logic            accept_s;
    logic            trap_s;
    logic            skid_full_nxt_s;
    ex_mem_payload_t in_payload_s;
    ex_mem_payload_t out_payload_s;

    // Accept qualification and trap detection; a trapped entry keeps its result
    // but loses every architectural side effect.
    always_comb begin
        accept_s = in_valid & in_ready_r & ~flush;
        trap_s   = trap_en & alu_ovf & is_trapping_op(alu_op);
        in_payload_s.result     = alu_out;
        in_payload_s.store_data = store_data;
        in_payload_s.dest       = dest_reg;
        if (trap_s) begin
            in_payload_s.reg_write = 1'b0;
            in_payload_s.mem_read  = 1'b0;
            in_payload_s.mem_write = 1'b0;
        end else begin
            in_payload_s.reg_write = reg_write;
            in_payload_s.mem_read  = mem_read;
            in_payload_s.mem_write = mem_write;
        end
    end

    pipe_skid_buf #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (accept_s),
        .in_data       (in_payload_s),
        .skid_full_nxt (skid_full_nxt_s),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_payload_s)
    );

    // Trap FSM next state; flush wins over exc_ack and over a trapping accept.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (flush) begin
                    state_s = ST_RUN;
                end else if (accept_s && trap_s) begin
                    state_s = ST_TRAP;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_TRAP: begin
                if (flush || exc_ack) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_TRAP;
                end
            end
            default: state_s = ST_RUN;
        endcase
    end

    // State and registered status outputs, all derived from next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_RUN;
            in_ready_r     <= 1'b1;
            exc_ovf_r      <= 1'b0;
            branch_taken_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            in_ready_r     <= ~skid_full_nxt_s & (state_s == ST_RUN);
            exc_ovf_r      <= (state_s == ST_TRAP);
            branch_taken_r <= accept_s & branch & alu_zero & ~trap_s;
        end
    end

    assign in_ready     = in_ready_r;
    assign exc_ovf      = exc_ovf_r;
    assign branch_taken = branch_taken_r;
    assign m_result     = out_payload_s.result;
    assign m_store_data = out_payload_s.store_data;
    assign m_dest       = out_payload_s.dest;
    assign m_reg_write  = out_payload_s.reg_write;
    assign m_mem_read   = out_payload_s.mem_read;
    assign m_mem_write  = out_payload_s.mem_write;

`ifdef EX_MEM_FWD_EN
    assign fwd_valid = out_valid & out_payload_s.reg_write & (out_payload_s.dest != '0);
    assign fwd_reg   = out_payload_s.dest;
    assign fwd_data  = out_payload_s.result;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: handshake, skid ordering,
// overflow trap, branch pulse, flush and reset.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        alu_ovf;
    logic        trap_en;
    logic [31:0] store_data;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        flush;
    logic        exc_ack;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] m_result;
    logic [31:0] m_store_data;
    logic [4:0]  m_dest;
    logic        m_reg_write;
    logic        m_mem_read;
    logic        m_mem_write;
    logic        branch_taken;
    logic        exc_ovf;
`ifdef EX_MEM_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    ex_mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_op       (alu_op),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .alu_ovf      (alu_ovf),
        .trap_en      (trap_en),
        .store_data   (store_data),
        .dest_reg     (dest_reg),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .branch       (branch),
        .flush        (flush),
        .exc_ack      (exc_ack),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .m_result     (m_result),
        .m_store_data (m_store_data),
        .m_dest       (m_dest),
        .m_reg_write  (m_reg_write),
        .m_mem_read   (m_mem_read),
        .m_mem_write  (m_mem_write),
        .branch_taken (branch_taken),
        .exc_ovf      (exc_ovf)
`ifdef EX_MEM_FWD_EN
        ,
        .fwd_valid    (fwd_valid),
        .fwd_reg      (fwd_reg),
        .fwd_data     (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] res,
                         input logic [4:0] dst, input logic rw, input logic te,
                         input logic ovf, input logic zero, input logic br);
        in_valid   = v;
        alu_op     = op;
        alu_out    = res;
        dest_reg   = dst;
        reg_write  = rw;
        trap_en    = te;
        alu_ovf    = ovf;
        alu_zero   = zero;
        branch     = br;
        store_data = res ^ 32'hFFFF_0000;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; exc_ack = 1'b0; out_ready = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        checks++; if (exc_ovf !== 1'b0) begin errors++; $display("FAIL reset_exc_ovf: got %0b expected 0", exc_ovf); end
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL reset_branch: got %0b expected 0", branch_taken); end
        checks++; if (m_result !== 32'd0) begin errors++; $display("FAIL reset_m_result: got %0h expected 0", m_result); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_add();
        out_ready = 1'b1;
        drive(1'b1, 4'd3, 32'h0000_0005, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid: got %0b expected 1", out_valid); end
        checks++; if (m_result !== 32'd5) begin errors++; $display("FAIL add_result: got %0h expected 5", m_result); end
        checks++; if (m_dest !== 5'd8) begin errors++; $display("FAIL add_dest: got %0d expected 8", m_dest); end
        checks++; if (m_reg_write !== 1'b1) begin errors++; $display("FAIL add_reg_write: got %0b expected 1", m_reg_write); end
        checks++; if (m_store_data !== 32'hFFFF_0005) begin errors++; $display("FAIL add_store_data: got %0h expected ffff0005", m_store_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drained: got %0b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 4'd3, 32'd1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after1: got %0b expected 1", in_ready); end
        drive(1'b1, 4'd3, 32'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %0b expected 0", in_ready); end
        drive(1'b1, 4'd3, 32'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (m_result !== 32'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold1: got %0h/%0b expected 1/1", m_result, out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_held: got %0b expected 0", in_ready); end
        out_ready = 1'b1;
        tick();
        checks++; if (m_result !== 32'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: got %0h/%0b expected 2/1", m_result, out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_rise: got %0b expected 1", in_ready); end
        tick();
        drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (m_result !== 32'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_third: got %0h/%0b expected 3/1", m_result, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup: got %0b expected 0", out_valid); end
    endtask

    task automatic test_trap();
        out_ready = 1'b1;
        drive(1'b1, 4'd4, 32'h8000_0000, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1 || m_result !== 32'h8000_0000) begin errors++; $display("FAIL trap_entry: got %0b/%0h expected 1/80000000", out_valid, m_result); end
        checks++; if (m_reg_write !== 1'b0) begin errors++; $display("FAIL trap_reg_write: got %0b expected 0", m_reg_write); end
        checks++; if (exc_ovf !== 1'b1) begin errors++; $display("FAIL trap_exc_ovf: got %0b expected 1", exc_ovf); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL trap_in_ready: got %0b expected 0", in_ready); end
        drive(1'b1, 4'd3, 32'd7, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL trap_no_accept: got %0b expected 0", out_valid); end
        checks++; if (exc_ovf !== 1'b1) begin errors++; $display("FAIL trap_level: got %0b expected 1", exc_ovf); end
        drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        checks++; if (exc_ovf !== 1'b0) begin errors++; $display("FAIL trap_ack_exc: got %0b expected 0", exc_ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL trap_ack_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_no_trap();
        out_ready = 1'b1;
        drive(1'b1, 4'd4, 32'h8000_0000, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (m_reg_write !== 1'b1 || exc_ovf !== 1'b0) begin errors++; $display("FAIL subu_no_trap: got rw=%0b exc=%0b expected 1/0", m_reg_write, exc_ovf); end
        drive(1'b1, 4'd6, 32'h1234_5678, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (m_reg_write !== 1'b1 || exc_ovf !== 1'b0 || m_result !== 32'h1234_5678) begin errors++; $display("FAIL mult_no_trap: got rw=%0b exc=%0b res=%0h expected 1/0/12345678", m_reg_write, exc_ovf, m_result); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mult_in_ready: got %0b expected 1", in_ready); end
        tick();
    endtask

    task automatic test_branch();
        out_ready = 1'b1;
        drive(1'b1, 4'd5, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL branch_pulse: got %0b expected 1", branch_taken); end
        tick();
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL branch_single: got %0b expected 0", branch_taken); end
        drive(1'b1, 4'd5, 32'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL branch_not_taken: got %0b expected 0", branch_taken); end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 4'd3, 32'hA, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd3, 32'hB, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_prefill: got rdy=%0b vld=%0b expected 0/1", in_ready, out_valid); end
        drive(1'b1, 4'd3, 32'hC, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %0b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %0b expected 1", in_ready); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %0b expected 0", out_valid); end
    endtask

    task automatic test_reset_in_trap();
        out_ready = 1'b0;
        drive(1'b1, 4'd3, 32'h7FFF_FFFF, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (exc_ovf !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL rst_trap_setup: got exc=%0b vld=%0b expected 1/1", exc_ovf, out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || exc_ovf !== 1'b0) begin errors++; $display("FAIL rst_trap_state: got vld=%0b exc=%0b expected 0/0", out_valid, exc_ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_trap_ready: got %0b expected 1", in_ready); end
        checks++; if (m_result !== 32'd0 || m_dest !== 5'd0 || m_reg_write !== 1'b0) begin errors++; $display("FAIL rst_trap_outputs: got %0h/%0d/%0b expected 0/0/0", m_result, m_dest, m_reg_write); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_trap();
        test_no_trap();
        test_branch();
        test_flush();
        test_reset_in_trap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
